tm1638_key_reader: RTL
======================

TM1638_KEY_READER -- requirements
Module: tm1638_key_reader

Interface
REQ-001 Parameter CYCLES, default 1: SPI half-period H = CYCLES+1 i_Clk cycles; o_SPI_Clk period = 2H.
REQ-002 Parameter WAIT_CYCLES, default 25: i_Clk cycles between command and first read bit (>=1 us at 25 MHz).
REQ-003 i_Clk  input  1  single clock; all logic on rising edge.
REQ-004 i_Rst  input  1  reset, synchronous, active-high.
REQ-005 i_Start  input  1  request one key-scan transaction; sampled only when o_Busy=0.
REQ-006 o_Busy  output  1  high from the edge accepting i_Start until the transaction ends; used by top level to arbitrate the shared bus with the display writer.
REQ-007 o_Keys_Valid  output  1  one-cycle pulse: o_Keys and o_Raw updated.
REQ-008 o_Keys  output  8  decoded buttons S1..S8, 1 = pressed.
REQ-009 o_Raw  output  32  four scan bytes; byte0 in bits [7:0].
REQ-010 o_SPI_Stb  output  1  strobe, active-low, idle high.
REQ-011 o_SPI_Clk  output  1  serial clock, idle high.
REQ-012 io_SPI_Dio  inout  1  data; driven during command, 'z' otherwise.

Function
REQ-013 States: IDLE, START, CMD, WAIT, READ, STOP; all outputs registered.
REQ-014 IDLE: Stb=1, Clk=1, Dio='z', Busy=0; i_Start=1 -> START, Busy=1.
REQ-015 START (H cycles): Stb=0, Clk=1, Dio drives command bit0 -> CMD.
REQ-016 CMD: 8 bits of 0x42, LSB first; per bit Clk=0 for H cycles, then Clk=1 for H cycles; Dio changes only on the falling phase start -> WAIT.
REQ-017 WAIT (WAIT_CYCLES): Stb=0, Clk=1, Dio='z' -> READ.
REQ-018 READ: 32 bits, LSB first per byte, bytes 0..3; Clk=0 for H cycles, Clk=1 for H cycles; Dio sampled on the i_Clk edge where o_SPI_Clk goes 0->1.
REQ-019 After the 32nd high phase: Stb=1, o_Keys_Valid=1 for one cycle -> STOP.
REQ-020 STOP (H cycles): Stb=1, Clk=1, Busy=1 -> IDLE; guarantees minimum strobe-high time.
REQ-021 Latency: o_Keys_Valid asserted 81H+WAIT_CYCLES cycles after the i_Start-accepting edge; Busy high for 82H+WAIT_CYCLES cycles.
REQ-022 Decode: o_Keys[i] = byte_i bit0, o_Keys[i+4] = byte_i bit4, for i=0..3; other raw bits appear only in o_Raw.
REQ-023 o_Keys/o_Raw hold their value between transactions; shift register must not alter them mid-scan.
REQ-024 i_Start while Busy=1 is ignored (not queued).
REQ-025 Bit and phase counters wrap exactly at 8, 32, H, WAIT_CYCLES; no extra clock edge emitted.

Reset
REQ-026 i_Rst=1 at any edge (including mid-transaction): next state IDLE, Stb=1, Clk=1, Dio='z', Busy=0, o_Keys_Valid=0, o_Keys=0, o_Raw=0, counters=0.
REQ-027 i_Rst and i_Start together: reset wins, no transaction starts.

Structure
REQ-028 Shared package tm1638_pkg holds CMD_READ_KEYS=8'h42, the state enum, and widths (8 keys, 32 raw bits).
REQ-029 One sub-module spi_phase_timer: counts H cycles, emits fall/rise phase strobes; reusable by the display writer.

Verification (CYCLES=1, WAIT_CYCLES=4, device model drives Dio on Clk falling edge)
REQ-030 Reset, then idle 20 cycles -> Stb=1, Clk=1, Dio='z', Busy=0, o_Keys=0x00.
REQ-031 i_Start one cycle, model returns bytes 01,00,10,00 -> Valid exactly 166 cycles later; o_Raw=0x00100001, o_Keys=0x41; Busy high 168 cycles.
REQ-032 Monitor CMD phase -> 8 rising Clk edges with Dio bits 0,1,0,0,0,0,1,0 (0x42 LSB first), Dio 'z' from WAIT start.
REQ-033 Pulse i_Start during Busy -> ignored; exactly one Valid pulse, 40 rising Clk edges total.
REQ-034 Assert i_Rst at cycle 60 of a scan -> next cycle Stb=1, Clk=1, Busy=0, Dio='z', no Valid; new i_Start then completes normally.
REQ-035 Back-to-back: i_Start held high -> consecutive scans separated by Stb high >= H cycles; each returns model data 0x11,0x11,0x11,0x11 -> o_Keys=0xFF.

Source files
------------

// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared TM1638 command codes, widths, scan states and key decode
package tm1638_pkg;
  localparam logic [7:0] CMD_READ_KEYS = 8'h42;
  localparam int KEY_W = 8;
  localparam int RAW_W = 32;
  typedef enum logic [2:0] {IDLE, START, CMD, WAIT, READ, STOP} state_t;
  function automatic logic [KEY_W-1:0] decode_keys(input logic [RAW_W-1:0] raw);
    logic [KEY_W-1:0] k;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[i] = raw[8*i];
      k[i+4] = raw[8*i+4];
    end
    return k;
  endfunction
endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: counts SPI half-periods of CYCLES+1 clocks and strobes the fall/rise phase boundaries
module spi_phase_timer #(
  parameter int CYCLES = 1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic en,
  input  logic go_low,
  output logic tick,
  output logic fall,
  output logic rise
);
  localparam int H = CYCLES + 1;
  localparam int CW = $clog2(H + 1);
  logic [CW-1:0] cnt;
  logic ph;
  always_comb begin
    tick = en && !go_low && cnt == CW'(H - 1);
    fall = tick && ph;
    rise = tick && !ph;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst || !en) begin
      cnt <= '0;
      ph <= 1'b1;
    end else if (go_low) begin
      cnt <= '0;
      ph <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      ph <= ~ph;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader: issues the TM1638 read-keys command, shifts in four scan bytes and decodes S1..S8
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int CYCLES = 1,
  parameter int WAIT_CYCLES = 25
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  output logic             o_Busy,
  output logic             o_Keys_Valid,
  output logic [KEY_W-1:0] o_Keys,
  output logic [RAW_W-1:0] o_Raw,
  output logic             o_SPI_Stb,
  output logic             o_SPI_Clk,
  inout  wire              io_SPI_Dio
);
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  state_t state, nxt;
  logic [WW-1:0] wcnt;
  logic [4:0] bit_cnt, bit_nxt;
  logic [RAW_W-1:0] sh;
  logic dio_oe, dio_out, tick, fall, rise, go_low, last_bit, timer_en, done;
  assign io_SPI_Dio = dio_oe ? dio_out : 1'bz;
  spi_phase_timer #(.CYCLES(CYCLES)) u_timer (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .en    (timer_en),
    .go_low(go_low),
    .tick  (tick),
    .fall  (fall),
    .rise  (rise)
  );
  always_comb begin
    go_low = state == WAIT && wcnt == WW'(WAIT_CYCLES - 1);
    timer_en = state == START || state == CMD || state == READ || state == STOP || go_low;
    last_bit = bit_cnt == (state == READ ? 5'd31 : 5'd7);
    done = state == READ && fall && last_bit;
    nxt = state == IDLE && i_Start ? START
        : state == START && fall ? CMD
        : state == CMD && fall && last_bit ? WAIT
        : go_low ? READ
        : done ? STOP
        : state == STOP && tick ? IDLE
        : state;
    bit_nxt = state == IDLE ? 5'd0
            : (state == CMD || state == READ) && fall ? (last_bit ? 5'd0 : bit_cnt + 5'd1)
            : bit_cnt;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= IDLE;
      wcnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      dio_oe <= 1'b0;
      dio_out <= 1'b0;
      o_Busy <= 1'b0;
      o_Keys_Valid <= 1'b0;
      o_Keys <= '0;
      o_Raw <= '0;
      o_SPI_Stb <= 1'b1;
      o_SPI_Clk <= 1'b1;
    end else begin
      state <= nxt;
      bit_cnt <= bit_nxt;
      wcnt <= state == WAIT && !go_low ? wcnt + 1'b1 : '0;
      o_Busy <= nxt != IDLE;
      o_SPI_Stb <= nxt == IDLE || nxt == STOP;
      o_SPI_Clk <= (nxt == CMD || nxt == READ) ? ((fall || go_low) ? 1'b0 : rise ? 1'b1 : o_SPI_Clk) : 1'b1;
      dio_oe <= nxt == START || nxt == CMD;
      dio_out <= CMD_READ_KEYS[bit_nxt[2:0]];
      if (state == READ && rise) sh <= {io_SPI_Dio, sh[RAW_W-1:1]};
      o_Keys_Valid <= done;
      if (done) begin
        o_Raw <= sh;
        o_Keys <= decode_keys(sh);
      end
    end
  end
endmodule
